opora_load_ctrl: RTL and testbench
==================================

OPORA_LOAD_CTRL -- requirements
Module: opora_load_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): N, 4, number of convolution cores; MULT_N, 25, coefficients per core; NUM_OPORA, N*MULT_N (100), coefficients per frame; TIMEOUT, 4096, maximum clke cycles between accepted words inside a frame.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clke, in, 1, Ethernet-side clock; all logic on its rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- rx_valid, in, 1, word valid from Ethernet receive path.
- rx_sof, in, 1, marks the first (header) word of a frame; qualified by rx_valid.
- rx_data, in, 16, frame word.
- abort, in, 1, software abort; single-cycle pulse.
- rx_ready, out, 1, word accepted when rx_valid && rx_ready.
- koef_en, out, N, one-hot write strobe, one bit per core.
- koef_addr, out, $clog2(MULT_N), coefficient address inside the core.
- KOEF, out, 16, coefficient data.
- wr_bank, out, 1, shadow bank written (= ~active_bank).
- active_bank, out, 1, bank used by the convolution datapath.
- load_busy, out, 1, high while a frame is in progress.
- load_done, out, 1, one-cycle pulse on successful commit.
- load_err, out, 1, one-cycle pulse on frame rejection.
- err_code, out, 3, cause of the last rejection; held until next rejection.

Function
REQ-003 SHALL define frame: word0 header 16'hA55A with rx_sof=1; word1 length L; words 2..L+1 coefficients; word L+2 checksum = 16-bit modular sum of the coefficient words.
REQ-004 SHALL implement FSM states IDLE, HDR_LEN, DATA, CSUM, DONE, ERR.
REQ-005 IDLE: accepted word with rx_sof=1 and data==16'hA55A -> HDR_LEN; rx_sof=1 with other data -> ERR, err_code=1; words with rx_sof=0 accepted and discarded.
REQ-006 HDR_LEN: L==NUM_OPORA -> DATA, clear word index and checksum; otherwise -> ERR, err_code=2.
REQ-007 DATA: each accepted word adds to checksum and issues one write; after word NUM_OPORA-1 -> CSUM.
REQ-008 CSUM: word equal to checksum -> DONE; otherwise -> ERR, err_code=3.
REQ-009 DONE and ERR SHALL last exactly one cycle, then return to IDLE; rx_ready=0 in these states, 1 in all others.
REQ-010 Write index SHALL be kept as core counter c (0..N-1) and address counter a (0..MULT_N-1); a wraps to 0 at MULT_N-1 and increments c; no divider.
REQ-011 Write for an accepted DATA word SHALL appear registered one cycle later: koef_en = one-hot(c), koef_addr = a, KOEF = rx_data; koef_en is all-zero in every other cycle.
REQ-012 In DONE: active_bank toggles, load_done=1 for that cycle; wr_bank follows combinationally.
REQ-013 In ERR: load_err=1 for that cycle, err_code updated, active_bank unchanged.
REQ-014 Accepted word with rx_sof=1 in HDR_LEN, DATA or CSUM SHALL go to ERR with err_code=5; the word is dropped, not reinterpreted as a header.
REQ-015 An idle-gap counter SHALL clear on every accepted word and count in HDR_LEN/DATA/CSUM; reaching TIMEOUT -> ERR, err_code=4.
REQ-016 abort in HDR_LEN/DATA/CSUM -> ERR, err_code=6; abort in IDLE/DONE/ERR ignored.
REQ-017 Priority on a single cycle: abort > timeout > rx_sof error > normal word decode.
REQ-018 load_busy = 1 in HDR_LEN, DATA, CSUM.
REQ-019 Checksum arithmetic SHALL be 16-bit, carries discarded.

Reset
REQ-020 On rst: state IDLE, koef_en=0, koef_addr=0, KOEF=0, active_bank=0, load_done=0, load_err=0, err_code=0, counters 0; rx_ready=1 after release.
REQ-021 rst asserted mid-frame SHALL discard the frame without toggling active_bank and without emitting load_done or load_err.

Verification
REQ-022 Valid frame: A55A, 100, coefficients 1..100, checksum 16'h13BA -> 100 writes, koef_en 0001 for addr 0..24, 0010/0100/1000 for the next three groups; load_done once; active_bank 0->1.
REQ-023 Same frame with checksum 16'h13BB -> load_err, err_code=3, active_bank stays 0, rx_ready low exactly one cycle.
REQ-024 Header A55A, length 99 -> load_err, err_code=2, no koef_en pulse.
REQ-025 Stall of 4096 cycles after coefficient 50 -> load_err, err_code=4; next valid frame commits normally.
REQ-026 Word with rx_sof=1 at coefficient 30, and abort coinciding with timeout -> err_code=5 and err_code=6 respectively.
REQ-027 Back-to-back valid frames with rx_valid held high -> two load_done pulses; active_bank 0->1->0; no write lost.

Source files
------------

// File: rtl/opora_load_ctrl.sv
// rtl/opora_load_ctrl.sv - coefficient frame loader with shadow-bank commit
module opora_load_ctrl #(
    parameter int N         = 4,
    parameter int MULT_N    = 25,
    parameter int NUM_OPORA = N * MULT_N,
    parameter int TIMEOUT   = 4096,
    localparam int AW       = (MULT_N > 1) ? $clog2(MULT_N) : 1
) (
    input  logic          clke,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic          rx_sof,
    input  logic [15:0]   rx_data,
    input  logic          abort,
    output logic          rx_ready,
    output logic [N-1:0]  koef_en,
    output logic [AW-1:0] koef_addr,
    output logic [15:0]   KOEF,
    output logic          wr_bank,
    output logic          active_bank,
    output logic          load_busy,
    output logic          load_done,
    output logic          load_err,
    output logic [2:0]    err_code
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = $clog2(TIMEOUT + 1);

    localparam logic [15:0]   HDR_WORD = 16'hA55A;
    localparam logic [15:0]   LEN_WORD = 16'(NUM_OPORA);
    localparam logic [CW-1:0] C_LAST   = CW'(N - 1);
    localparam logic [AW-1:0] A_LAST   = AW'(MULT_N - 1);
    localparam logic [GW-1:0] GAP_LIM  = GW'(TIMEOUT);

    localparam logic [2:0] E_HDR   = 3'd1;
    localparam logic [2:0] E_LEN   = 3'd2;
    localparam logic [2:0] E_CSUM  = 3'd3;
    localparam logic [2:0] E_TMO   = 3'd4;
    localparam logic [2:0] E_SOF   = 3'd5;
    localparam logic [2:0] E_ABORT = 3'd6;

    typedef enum logic [2:0] {IDLE, HDR_LEN, DATA, CSUM, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [AW-1:0]   a_q, a_d;
    logic [15:0]     csum_q, csum_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [2:0]      err_q, err_d;
    logic            bank_q, bank_d;
    logic            wr_d;
    logic [N-1:0]    en_q;
    logic [AW-1:0]   addr_q;
    logic [15:0]     koef_q;

    logic busy;
    logic accept;
    logic timeout;

    assign busy     = (state_q == HDR_LEN) || (state_q == DATA) || (state_q == CSUM);
    assign rx_ready = (state_q != DONE) && (state_q != ERR);
    assign accept   = rx_valid && rx_ready;
    assign timeout  = busy && (gap_q == GAP_LIM);

    // Next-state decode: abort beats timeout beats stray SOF beats normal word handling
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        a_d     = a_q;
        csum_d  = csum_q;
        err_d   = err_q;
        wr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && rx_sof) begin
                    if (rx_data == HDR_WORD) begin
                        state_d = HDR_LEN;
                    end else begin
                        state_d = ERR;
                        err_d   = E_HDR;
                    end
                end
            end
            DONE, ERR: state_d = IDLE;
            default: begin
                if (abort) begin
                    state_d = ERR;
                    err_d   = E_ABORT;
                end else if (timeout) begin
                    state_d = ERR;
                    err_d   = E_TMO;
                end else if (accept && rx_sof) begin
                    state_d = ERR;
                    err_d   = E_SOF;
                end else if (accept) begin
                    if (state_q == HDR_LEN) begin
                        if (rx_data == LEN_WORD) begin
                            state_d = DATA;
                            c_d     = '0;
                            a_d     = '0;
                            csum_d  = '0;
                        end else begin
                            state_d = ERR;
                            err_d   = E_LEN;
                        end
                    end else if (state_q == DATA) begin
                        wr_d   = 1'b1;
                        csum_d = csum_q + rx_data;
                        if (a_q == A_LAST) begin
                            a_d = '0;
                            if (c_q == C_LAST) begin
                                state_d = CSUM;
                            end else begin
                                c_d = c_q + 1'b1;
                            end
                        end else begin
                            a_d = a_q + 1'b1;
                        end
                    end else begin
                        if (rx_data == csum_q) begin
                            state_d = DONE;
                        end else begin
                            state_d = ERR;
                            err_d   = E_CSUM;
                        end
                    end
                end
            end
        endcase
        gap_d  = (!busy || accept) ? '0 : gap_q + 1'b1;
        bank_d = (state_d == DONE) ? ~bank_q : bank_q;
    end

    // Control state, counters, checksum and bank selection
    always_ff @(posedge clke or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            a_q     <= '0;
            csum_q  <= '0;
            gap_q   <= '0;
            err_q   <= '0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            a_q     <= a_d;
            csum_q  <= csum_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            bank_q  <= bank_d;
        end
    end

    // Registered coefficient write port; strobe lasts one cycle per accepted data word
    always_ff @(posedge clke or posedge rst) begin
        if (rst) begin
            en_q   <= '0;
            addr_q <= '0;
            koef_q <= '0;
        end else if (wr_d) begin
            en_q   <= N'(1) << c_q;
            addr_q <= a_q;
            koef_q <= rx_data;
        end else begin
            en_q   <= '0;
        end
    end

    assign koef_en     = en_q;
    assign koef_addr   = addr_q;
    assign KOEF        = koef_q;
    assign active_bank = bank_q;
    assign wr_bank     = ~bank_q;
    assign load_busy   = busy;
    assign load_done   = (state_q == DONE);
    assign load_err    = (state_q == ERR);
    assign err_code    = err_q;

endmodule

// File: tb/tb_opora_load_ctrl.sv
// tb/tb_opora_load_ctrl.sv - randomized self-checking bench for opora_load_ctrl
module tb_opora_load_ctrl;

    localparam int N       = 4;
    localparam int MULT_N  = 25;
    localparam int NUM     = N * MULT_N;
    localparam int TIMEOUT = 4096;

    logic        clke = 1'b0;
    logic        rst  = 1'b1;
    logic        rx_valid = 1'b0;
    logic        rx_sof = 1'b0;
    logic [15:0] rx_data = '0;
    logic        abort = 1'b0;
    logic        rx_ready;
    logic [3:0]  koef_en;
    logic [4:0]  koef_addr;
    logic [15:0] KOEF;
    logic        wr_bank, active_bank, load_busy, load_done, load_err;
    logic [2:0]  err_code;

    opora_load_ctrl #(.N(N), .MULT_N(MULT_N), .NUM_OPORA(NUM), .TIMEOUT(TIMEOUT)) dut (
        .clke(clke), .rst(rst), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_data(rx_data),
        .abort(abort), .rx_ready(rx_ready), .koef_en(koef_en), .koef_addr(koef_addr),
        .KOEF(KOEF), .wr_bank(wr_bank), .active_bank(active_bank), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err), .err_code(err_code)
    );

    always #5 clke = ~clke;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_acc = 0;
    int err_cyc = 0;
    int n_done = 0, n_err = 0, n_nrdy = 0;
    logic [2:0] last_code = '0;
    logic exp_bank = 1'b0;

    logic [3:0]  obs_en[$];
    logic [4:0]  obs_addr[$];
    logic [15:0] obs_dat[$];
    logic [3:0]  exp_en[$];
    logic [4:0]  exp_addr[$];
    logic [15:0] exp_dat[$];
    logic [15:0] frm [0:NUM-1];

    always @(posedge clke) cyc <= cyc + 1;

    always @(negedge clke) begin
        if (koef_en != 4'b0) begin
            obs_en.push_back(koef_en);
            obs_addr.push_back(koef_addr);
            obs_dat.push_back(KOEF);
        end
        if (load_done) n_done++;
        if (load_err) begin
            n_err++;
            last_code = err_code;
            err_cyc   = cyc;
        end
        if (!rst && !rx_ready) n_nrdy++;
    end

    task automatic clear_obs();
        obs_en.delete(); obs_addr.delete(); obs_dat.delete();
        exp_en.delete(); exp_addr.delete(); exp_dat.delete();
        n_done = 0; n_err = 0; n_nrdy = 0;
    endtask

    function automatic int write_errs();
        int bad = 0;
        if (obs_en.size() != exp_en.size()) bad++;
        for (int i = 0; i < obs_en.size() && i < exp_en.size(); i++)
            if (obs_en[i] !== exp_en[i] || obs_addr[i] !== exp_addr[i] || obs_dat[i] !== exp_dat[i]) bad++;
        return bad;
    endfunction

    function automatic logic [15:0] frm_sum();
        int s = 0;
        for (int i = 0; i < NUM; i++) s = (s + int'(frm[i])) % 65536;
        return 16'(s);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NUM; i++) frm[i] = 16'($urandom);
    endtask

    task automatic put_word(input logic [15:0] d, input logic sof, input int gap);
        bit acc;
        int k = 0;
        rx_data = d; rx_sof = sof; rx_valid = 1'b1;
        do begin
            acc = rx_ready;
            @(posedge clke); #1;
            k++;
        end while (!acc && k < 20);
        if (!acc) begin checks++; $display("FAIL put_word: word %h not accepted within 20 cycles", d); end
        last_acc = cyc;
        if (gap > 0) begin
            rx_valid = 1'b0; rx_sof = 1'b0;
            repeat (gap) begin @(posedge clke); #1; end
        end
    endtask

    task automatic settle(input int n);
        rx_valid = 1'b0; rx_sof = 1'b0;
        repeat (n) begin @(posedge clke); #1; end
    endtask

    task automatic send_coefs(input int lo, input int hi, input int gmax);
        for (int i = lo; i < hi; i++) begin
            exp_en.push_back(4'(1 << (i / MULT_N)));
            exp_addr.push_back(5'(i % MULT_N));
            exp_dat.push_back(frm[i]);
            put_word(frm[i], 1'b0, $urandom_range(gmax, 0));
        end
    endtask

    task automatic send_frame(input logic [15:0] csum, input int gmax);
        put_word(16'hA55A, 1'b1, $urandom_range(gmax, 0));
        put_word(16'(NUM), 1'b0, $urandom_range(gmax, 0));
        send_coefs(0, NUM, gmax);
        put_word(csum, 1'b0, $urandom_range(gmax, 0));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clke); #1; end
        checks++; if (koef_en !== 4'b0) $display("FAIL rst_koef_en: got %b want 0000", koef_en); else passes++;
        checks++; if (koef_addr !== 5'd0) $display("FAIL rst_koef_addr: got %0d want 0", koef_addr); else passes++;
        checks++; if (KOEF !== 16'h0) $display("FAIL rst_KOEF: got %h want 0000", KOEF); else passes++;
        checks++; if (active_bank !== 1'b0) $display("FAIL rst_active_bank: got %b want 0", active_bank); else passes++;
        checks++; if ({load_done, load_err, load_busy} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {load_done, load_err, load_busy}); else passes++;
        checks++; if (err_code !== 3'd0) $display("FAIL rst_err_code: got %0d want 0", err_code); else passes++;
        rst = 1'b0;
        @(posedge clke); #1;
        checks++; if (rx_ready !== 1'b1) $display("FAIL rst_rx_ready: got %b want 1", rx_ready); else passes++;
        checks++; if (wr_bank !== 1'b1) $display("FAIL rst_wr_bank: got %b want 1", wr_bank); else passes++;
        exp_bank = 1'b0;
    endtask

    task automatic test_midframe_reset();
        clear_obs(); fill_random();
        put_word(16'hA55A, 1'b1, 0);
        put_word(16'(NUM), 1'b0, 1);
        send_coefs(0, 10, 1);
        rx_valid = 1'b0;
        rst = 1'b1; @(posedge clke); #1; rst = 1'b0;
        settle(4);
        exp_bank = 1'b0;
        checks++; if (n_done + n_err !== 0) $display("FAIL midrst_pulses: got %0d want 0", n_done + n_err); else passes++;
        checks++; if (active_bank !== exp_bank) $display("FAIL midrst_bank: got %b want %b", active_bank, exp_bank); else passes++;
        checks++; if (load_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", load_busy); else passes++;
    endtask

    task automatic test_valid_frame();
        clear_obs();
        for (int i = 0; i < NUM; i++) frm[i] = 16'(i + 1);
        put_word(16'h1234, 1'b0, 1);
        send_frame(16'h13BA, 2);
        settle(4);
        exp_bank = ~exp_bank;
        checks++; if (write_errs() !== 0) $display("FAIL valid_writes: got %0d bad of %0d want 0 bad of %0d", write_errs(), obs_en.size(), NUM); else passes++;
        checks++; if (n_done !== 1 || n_err !== 0) $display("FAIL valid_pulses: got done=%0d err=%0d want 1/0", n_done, n_err); else passes++;
        checks++; if (active_bank !== exp_bank || wr_bank !== ~exp_bank) $display("FAIL valid_bank: got %b/%b want %b", active_bank, wr_bank, exp_bank); else passes++;
    endtask

    task automatic test_bad_csum();
        clear_obs();
        for (int i = 0; i < NUM; i++) frm[i] = 16'(i + 1);
        send_frame(16'h13BB, 1);
        settle(4);
        checks++; if (n_err !== 1 || n_done !== 0) $display("FAIL csum_pulses: got err=%0d done=%0d want 1/0", n_err, n_done); else passes++;
        checks++; if (last_code !== 3'd3) $display("FAIL csum_code: got %0d want 3", last_code); else passes++;
        checks++; if (active_bank !== exp_bank) $display("FAIL csum_bank: got %b want %b", active_bank, exp_bank); else passes++;
        checks++; if (n_nrdy !== 1) $display("FAIL csum_ready_low: got %0d cycles want 1", n_nrdy); else passes++;
        checks++; if (write_errs() !== 0) $display("FAIL csum_writes: got %0d bad want 0", write_errs()); else passes++;
    endtask

    task automatic test_bad_header();
        clear_obs();
        put_word(16'h0063, 1'b0, 0);
        put_word(16'hBEEF, 1'b1, 0);
        settle(3);
        checks++; if (n_err !== 1 || last_code !== 3'd1) $display("FAIL hdr_err: got err=%0d code=%0d want 1/1", n_err, last_code); else passes++;
        clear_obs();
        put_word(16'hA55A, 1'b1, 0);
        put_word(16'd99, 1'b0, 0);
        settle(4);
        checks++; if (n_err !== 1 || last_code !== 3'd2) $display("FAIL len_err: got err=%0d code=%0d want 1/2", n_err, last_code); else passes++;
        checks++; if (obs_en.size() !== 0) $display("FAIL len_writes: got %0d want 0", obs_en.size()); else passes++;
    endtask

    task automatic test_timeout();
        int k = 0;
        clear_obs(); fill_random();
        put_word(16'hA55A, 1'b1, 0);
        put_word(16'(NUM), 1'b0, 0);
        send_coefs(0, 50, 0);
        rx_valid = 1'b0;
        while (n_err == 0 && k < TIMEOUT + 200) begin @(posedge clke); #1; k++; end
        checks++; if (n_err !== 1 || last_code !== 3'd4) $display("FAIL tmo_err: got err=%0d code=%0d want 1/4", n_err, last_code); else passes++;
        checks++; if (err_cyc - last_acc < TIMEOUT || err_cyc - last_acc > TIMEOUT + 2) $display("FAIL tmo_delay: got %0d cycles want %0d..%0d", err_cyc - last_acc, TIMEOUT, TIMEOUT + 2); else passes++;
        checks++; if (write_errs() !== 0) $display("FAIL tmo_writes: got %0d bad want 0", write_errs()); else passes++;
        clear_obs(); fill_random();
        send_frame(frm_sum(), 2);
        settle(4);
        exp_bank = ~exp_bank;
        checks++; if (n_done !== 1 || active_bank !== exp_bank) $display("FAIL tmo_recover: got done=%0d bank=%b want 1/%b", n_done, active_bank, exp_bank); else passes++;
        checks++; if (write_errs() !== 0) $display("FAIL tmo_recover_writes: got %0d bad want 0", write_errs()); else passes++;
    endtask

    task automatic test_sof_error();
        clear_obs(); fill_random();
        put_word(16'hA55A, 1'b1, 0);
        put_word(16'(NUM), 1'b0, 1);
        send_coefs(0, 30, 1);
        put_word(16'hA55A, 1'b1, 0);
        put_word(16'(NUM), 1'b0, 0);
        settle(3);
        checks++; if (n_err !== 1 || last_code !== 3'd5) $display("FAIL sof_err: got err=%0d code=%0d want 1/5", n_err, last_code); else passes++;
        checks++; if (load_busy !== 1'b0) $display("FAIL sof_not_header: got busy=%b want 0", load_busy); else passes++;
        checks++; if (write_errs() !== 0) $display("FAIL sof_writes: got %0d bad want 0", write_errs()); else passes++;
    endtask

    task automatic test_abort_timeout();
        clear_obs(); fill_random();
        abort = 1'b1; @(posedge clke); #1; abort = 1'b0;
        put_word(16'hA55A, 1'b1, 0);
        put_word(16'(NUM), 1'b0, 0);
        send_coefs(0, 10, 0);
        rx_valid = 1'b0;
        repeat (TIMEOUT) begin @(posedge clke); #1; end
        abort = 1'b1; @(posedge clke); #1; abort = 1'b0;
        settle(3);
        checks++; if (n_err !== 1 || last_code !== 3'd6) $display("FAIL abort_tmo: got err=%0d code=%0d want 1/6", n_err, last_code); else passes++;
        checks++; if (active_bank !== exp_bank) $display("FAIL abort_bank: got %b want %b", active_bank, exp_bank); else passes++;
    endtask

    task automatic test_random_frames();
        int exp_done = 0, exp_err = 0;
        clear_obs();
        for (int f = 0; f < 3; f++) begin
            bit corrupt = 1'($urandom);
            fill_random();
            send_frame(corrupt ? frm_sum() ^ 16'(1 << $urandom_range(15, 0)) : frm_sum(), 3);
            settle(3);
            if (corrupt) exp_err++; else begin exp_done++; exp_bank = ~exp_bank; end
        end
        checks++; if (n_done !== exp_done || n_err !== exp_err) $display("FAIL rand_pulses: got %0d/%0d want %0d/%0d", n_done, n_err, exp_done, exp_err); else passes++;
        checks++; if (active_bank !== exp_bank) $display("FAIL rand_bank: got %b want %b", active_bank, exp_bank); else passes++;
        checks++; if (write_errs() !== 0) $display("FAIL rand_writes: got %0d bad want 0", write_errs()); else passes++;
    endtask

    task automatic test_back_to_back();
        logic b0;
        clear_obs();
        b0 = exp_bank;
        for (int f = 0; f < 2; f++) begin
            fill_random();
            send_frame(frm_sum(), 0);
            exp_bank = ~exp_bank;
        end
        settle(4);
        checks++; if (n_done !== 2 || n_err !== 0) $display("FAIL b2b_pulses: got done=%0d err=%0d want 2/0", n_done, n_err); else passes++;
        checks++; if (active_bank !== b0 || active_bank !== exp_bank) $display("FAIL b2b_bank: got %b want %b", active_bank, b0); else passes++;
        checks++; if (obs_en.size() !== 2 * NUM) $display("FAIL b2b_count: got %0d want %0d", obs_en.size(), 2 * NUM); else passes++;
        checks++; if (write_errs() !== 0) $display("FAIL b2b_writes: got %0d bad want 0", write_errs()); else passes++;
    endtask

    initial begin
        test_reset();
        test_midframe_reset();
        test_valid_frame();
        test_bad_csum();
        test_bad_header();
        test_timeout();
        test_sof_error();
        test_abort_timeout();
        test_random_frames();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
